// File: rtl/pc_gen_if.sv
// Fetch-address handshake bundle between pc_gen and instruction memory / pipeline control.
interface pc_gen_if #(
  parameter int XLEN = 32
) ();
  logic            stall;
  logic            halt;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_addr;
  logic            pc_ready;
  logic [XLEN-1:0] pc_out;
  logic            pc_valid;
  logic            range_err;
  logic            misalign;

  modport master (
    input  stall, halt, redirect_valid, redirect_addr, pc_ready,
    output pc_out, pc_valid, range_err, misalign
  );

  modport slave (
    output stall, halt, redirect_valid, redirect_addr, pc_ready,
    input  pc_out, pc_valid, range_err, misalign
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: sequential advance, stall/halt, range-checked redirects.
// Define PC_MISALIGN_EN to trap misaligned redirect targets instead of truncating them.
//
// state  | meaning
// BOOT   | one cycle after reset release, no fetch issued
// RUN    | fetch request live, PC advances on accepted fetch
// HALTED | fetching stopped until a redirect arrives
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter int              INC       = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] PC_MAX    = '1,
  parameter logic [XLEN-1:0] TRAP_VEC  = '0
) (
  input  logic      clk,
  input  logic      rst,
  pc_gen_if.master  bus
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt;
  logic [XLEN:0]   pc_inc;
  logic            tgt_range, tgt_mis;
  logic            pc_valid_q;
  logic            range_err_q, range_err_d;
  logic            misalign_q, misalign_d;

  // Out-of-range check wins over the alignment check.
  always_comb begin
    tgt_range = (bus.redirect_addr > PC_MAX);
    tgt_mis   = 1'b0;
    tgt       = bus.redirect_addr & ~ALIGN_MASK;
    if (tgt_range) begin
      tgt = TRAP_VEC;
    end
`ifdef PC_MISALIGN_EN
    else if (|(bus.redirect_addr & ALIGN_MASK)) begin
      tgt_mis = 1'b1;
      tgt     = TRAP_VEC;
    end
`endif
  end

  // One extra bit so that a carry out of XLEN also counts as exceeding PC_MAX.
  assign pc_inc = {1'b0, pc_q} + (XLEN+1)'(INC);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    range_err_d = 1'b0;
    misalign_d  = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.redirect_valid) begin
          pc_d        = tgt;
          range_err_d = tgt_range;
          misalign_d  = tgt_mis;
        end else if (bus.halt) begin
          state_d = HALTED;
        end else if (!bus.stall && pc_valid_q && bus.pc_ready) begin
          pc_d = (pc_inc > {1'b0, PC_MAX}) ? RESET_VEC : pc_inc[XLEN-1:0];
        end
      end
      HALTED: begin
        if (bus.redirect_valid) begin
          pc_d        = tgt;
          range_err_d = tgt_range;
          misalign_d  = tgt_mis;
          state_d     = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VEC;
      pc_valid_q  <= 1'b0;
      range_err_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_valid_q  <= (state_d == RUN);
      range_err_q <= range_err_d;
      misalign_q  <= misalign_d;
    end
  end

  assign bus.pc_out    = pc_q;
  assign bus.pc_valid  = pc_valid_q;
  assign bus.range_err = range_err_q;
  assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed test-plan sequence plus random traffic against a behavioural model.
module tb_pc_gen;

  localparam int XLEN      = 8;
  localparam int INC       = 4;
  localparam int RESET_VEC = 'h00;
  localparam int PC_MAX    = 'h7F;
  localparam int TRAP_VEC  = 'h10;

  logic clk;
  logic rst;

  pc_gen_if #(.XLEN(XLEN)) bus ();

  pc_gen #(
    .XLEN      (XLEN),
    .INC       (INC),
    .RESET_VEC (8'(RESET_VEC)),
    .PC_MAX    (8'(PC_MAX)),
    .TRAP_VEC  (8'(TRAP_VEC))
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode 0 = booting, 1 = fetching, 2 = halted.
  int m_mode;
  int m_pc;
  bit m_re;
  bit m_mis;
  bit m_stall, m_halt, m_rv, m_rdy;
  int m_addr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = RESET_VEC;
    m_re   = 1'b0;
    m_mis  = 1'b0;
  endtask

  task automatic model_target(input int addr);
    if (addr > PC_MAX) begin
      m_pc = TRAP_VEC;
      m_re = 1'b1;
    end else if (addr % INC != 0) begin
`ifdef PC_MISALIGN_EN
      m_pc  = TRAP_VEC;
      m_mis = 1'b1;
`else
      m_pc = addr - (addr % INC);
`endif
    end else begin
      m_pc = addr;
    end
  endtask

  task automatic model_edge();
    m_re  = 1'b0;
    m_mis = 1'b0;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (m_rv)         model_target(m_addr);
      else if (m_halt)  m_mode = 2;
      else if (m_stall) m_pc = m_pc;
      else if (m_rdy)   m_pc = (m_pc + INC > PC_MAX) ? RESET_VEC : m_pc + INC;
    end else begin
      if (m_rv) begin
        model_target(m_addr);
        m_mode = 1;
      end
    end
  endtask

  task automatic compare_all(input string where);
    check_eq({where, ".pc_out"},    64'(bus.pc_out),    64'(m_pc));
    check_eq({where, ".pc_valid"},  64'(bus.pc_valid),  64'(m_mode == 1));
    check_eq({where, ".range_err"}, 64'(bus.range_err), 64'(m_re));
    check_eq({where, ".misalign"},  64'(bus.misalign),  64'(m_mis));
  endtask

  task automatic step(input bit s, input bit h, input bit rv, input int addr, input bit rdy, input string where);
    bus.stall          = s;
    bus.halt           = h;
    bus.redirect_valid = rv;
    bus.redirect_addr  = 8'(addr);
    bus.pc_ready       = rdy;
    m_stall = s; m_halt = h; m_rv = rv; m_addr = addr; m_rdy = rdy;
    @(posedge clk);
    model_edge();
    #1;
    compare_all(where);
  endtask

  // Asserted between edges so the async path is observed before any clock.
  task automatic do_reset(input int n, input string where);
    rst = 1'b1;
    #1;
    model_reset();
    check_eq({where, ".async_pc"},    64'(bus.pc_out),   64'(RESET_VEC));
    check_eq({where, ".async_valid"}, 64'(bus.pc_valid), 64'd0);
    compare_all(where);
    repeat (n) @(posedge clk);
    #1;
    compare_all({where, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    rst                = 1'b0;
    bus.stall          = 1'b0;
    bus.halt           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
    bus.pc_ready       = 1'b0;
    model_reset();
    m_stall = 0; m_halt = 0; m_rv = 0; m_rdy = 0; m_addr = 0;
    #2;

    do_reset(3, "por");
    step(0, 0, 0, 0, 1, "boot");
    check_eq("boot_first_pc", 64'(bus.pc_out), 64'h00);
    check_eq("boot_valid", 64'(bus.pc_valid), 64'd1);
    step(0, 0, 0, 0, 1, "seq1");
    check_eq("seq_pc4", 64'(bus.pc_out), 64'h04);
    step(0, 0, 0, 0, 1, "seq2");
    check_eq("seq_pc8", 64'(bus.pc_out), 64'h08);
    step(0, 0, 0, 0, 0, "bp1");
    step(0, 0, 0, 0, 0, "bp2");
    check_eq("bp_hold8", 64'(bus.pc_out), 64'h08);
    step(0, 0, 0, 0, 1, "bp_rel");
    check_eq("bp_then12", 64'(bus.pc_out), 64'h0C);

    step(1, 0, 1, 'h40, 1, "redir_stall");
    check_eq("redir_over_stall", 64'(bus.pc_out), 64'h40);
    step(0, 0, 0, 0, 1, "redir_next");
    check_eq("redir_then44", 64'(bus.pc_out), 64'h44);

    step(0, 0, 1, 'h90, 1, "range");
    check_eq("range_trap", 64'(bus.pc_out), 64'h10);
    check_eq("range_pulse", 64'(bus.range_err), 64'd1);
    step(0, 0, 0, 0, 0, "range_end");
    check_eq("range_pulse_end", 64'(bus.range_err), 64'd0);

    step(0, 0, 1, 'h22, 0, "align");
`ifdef PC_MISALIGN_EN
    check_eq("align_trap", 64'(bus.pc_out), 64'h10);
    check_eq("align_pulse", 64'(bus.misalign), 64'd1);
`else
    check_eq("align_trunc", 64'(bus.pc_out), 64'h20);
    check_eq("align_no_pulse", 64'(bus.misalign), 64'd0);
`endif

    step(0, 0, 1, 'h20, 0, "halt_setup");
    step(0, 1, 0, 0, 1, "halt");
    for (int i = 0; i < 5; i++) begin
      step(bit'($urandom_range(1)), bit'($urandom_range(1)), 0, 0, bit'($urandom_range(1)), "halted");
      check_eq("halted_pc", 64'(bus.pc_out), 64'h20);
      check_eq("halted_valid", 64'(bus.pc_valid), 64'd0);
    end
    step(0, 1, 1, 'h50, 1, "unhalt");
    check_eq("unhalt_pc", 64'(bus.pc_out), 64'h50);
    check_eq("unhalt_valid", 64'(bus.pc_valid), 64'd1);

    step(0, 0, 1, 'h7C, 1, "wrap_setup");
    step(0, 0, 0, 0, 1, "wrap");
    check_eq("wrap_pc", 64'(bus.pc_out), 64'(RESET_VEC));
    check_eq("wrap_no_err", 64'(bus.range_err), 64'd0);
    step(0, 0, 0, 0, 1, "post_wrap");
    do_reset(2, "mid_rst");

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset(int'($urandom_range(1, 3)), "rnd_rst");
      end else begin
        step(($urandom_range(3) == 0),
             ($urandom_range(15) == 0),
             ($urandom_range(7) == 0),
             int'($urandom_range(255)),
             ($urandom_range(3) != 0),
             "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the instruction-fetch stage. Holds the fetch address, advances it by a fixed increment on each accepted fetch, and applies stalls, branch/jump redirects and halt requests from later pipeline stages. Drives the instruction-memory address through a valid/ready handshake, and range-checks redirect targets. Replaces the fixed 8-bit counter with a configurable-width, handshake-aware block.

## Interface

- XLEN, 32, PC width in bits (8..64).
- INC, 4, sequential increment; power of two, at least 1.
- RESET_VEC, 0, PC value loaded on reset.
- PC_MAX, 2^XLEN-1, highest legal fetch address (inclusive).
- TRAP_VEC, 0, PC loaded on an illegal redirect target.

Ports:

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold the PC (hazard from decode/execute).
- halt  in  1  stop fetching.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_addr  in  XLEN  redirect target, unsigned.
- pc_ready  in  1  instruction memory accepts pc_out.
- pc_out  out  XLEN  current fetch address (registered).
- pc_valid  out  1  pc_out is a live fetch request.
- range_err  out  1  one-cycle pulse: redirect target exceeded PC_MAX.
- misalign  out  1  one-cycle pulse: redirect target not INC-aligned (only with PC_MISALIGN_EN).

## Operation

- States: BOOT, RUN, HALTED.
- Reset (asynchronous):
  - State BOOT; pc_out = RESET_VEC.
  - pc_valid = 0; range_err = 0; misalign = 0.
- BOOT: on the first clock edge after rst deasserts, go to RUN. Inputs are ignored in BOOT.
- RUN, per edge, first matching rule wins:
  1. redirect_valid: pc_out <= target (see target rules).
  2. halt: go to HALTED; pc_out held.
  3. stall: pc_out held.
  4. pc_valid && pc_ready: pc_out <= pc_out + INC.
  5. Otherwise: hold.
- HALTED:
  - pc_valid = 0; pc_out held; halt and stall ignored.
  - redirect_valid: load target, return to RUN.
- pc_valid = 1 exactly when state is RUN.
- Target rules:
  - redirect_addr > PC_MAX: load TRAP_VEC, pulse range_err.
  - Otherwise, apply the alignment rule (see Configuration), then load.
- Arithmetic: the increment is modulo 2^XLEN. If pc_out + INC > PC_MAX, pc_out wraps to RESET_VEC. No error is flagged on wrap.
- Simultaneous events:
  - redirect_valid overrides stall, halt and handshake advance.
  - A fetch accepted in the same cycle as a redirect is dropped; the PC does not advance past it.
- Reset mid-operation takes effect immediately, including in HALTED and during a redirect.

## Timing

- pc_out, pc_valid, range_err and misalign are all registered; no combinational input-to-output path.
- Redirect latency: target appears on pc_out at the edge that samples redirect_valid, i.e. one cycle after assertion.
- Sequential fetch: one address per cycle when pc_ready is held high and no stall.
- pc_out must stay stable while pc_valid=1 and pc_ready=0, unless a redirect occurs.
- Error pulses are high for exactly the cycle after the offending redirect.
- After rst falls: one BOOT cycle, then pc_valid rises with pc_out = RESET_VEC.

## Configuration

- PC_MISALIGN_EN defined:
  - A redirect target whose low log2(INC) bits are nonzero loads TRAP_VEC and pulses misalign.
  - If a target is both out of range and misaligned, range_err takes priority; misalign stays 0.
- PC_MISALIGN_EN undefined:
  - The low log2(INC) bits of the target are forced to zero and the address is loaded.
  - misalign is tied to 0.
- With INC=1 the macro has no effect.

## Test plan

- Reset/boot: rst high 3 cycles, then low, pc_ready=1 -> pc_valid=0 for one cycle, then pc_out = 0, 4, 8, 12 on consecutive cycles.
- Backpressure: pc_ready low for 2 cycles at pc_out=8 -> pc_out holds 8 for 2 cycles, then 12.
- Redirect vs stall: stall=1 and redirect_valid=1 with addr=0x40 -> next cycle pc_out=0x40; when stall drops, 0x44 follows.
- Range/align (XLEN=8, PC_MAX=0x7F, TRAP_VEC=0x10):
  - redirect 0x90 -> pc_out=0x10, range_err pulses once.
  - redirect 0x22, macro on -> pc_out=0x10, misalign pulses.
  - redirect 0x22, macro off -> pc_out=0x20.
- Halt: halt at pc_out=0x20 -> pc_valid=0 and pc_out=0x20 held for 5 cycles; redirect to 0x50 -> pc_valid=1, pc_out=0x50.
- Wrap/reset: XLEN=8, INC=4, pc_out=0xFC accepted -> pc_out=0x00; assert rst mid-stream -> pc_out=RESET_VEC and pc_valid=0 immediately, without waiting for a clock edge.
